// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - issue, in-flight tracking and result buffering for the 2-stage multiplier
module mul_issue_ctrl #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   input  logic [4:0]  req_rd,
   input  logic        flush,
   output logic        mul_start,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic [2:0]  mul_ctrl,
   input  logic [31:0] mul_result,
   input  logic        mul_done,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        busy
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   localparam ptr_t LAST_PTR = ptr_t'(FIFO_DEPTH - 1);
   localparam cnt_t DEPTH_C  = cnt_t'(FIFO_DEPTH);

   // tracking pipe: one {valid, rd} per multiplier stage
   logic        v0_q, v0_d, v1_q, v1_d;
   logic [4:0]  rd0_q, rd0_d, rd1_q, rd1_d;

   // result buffer and its bookkeeping
   logic [31:0] fifo_data_q [FIFO_DEPTH];
   logic [4:0]  fifo_rd_q   [FIFO_DEPTH];
   ptr_t        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   cnt_t        count_q, count_d;

   // in-flight plus buffered operations; caps acceptance so a push never finds the buffer full
   cnt_t        occ_q, occ_d;

   logic        accept, push, pop;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
   endfunction

   // handshake, issue to the multiplier and head-of-buffer outputs
   always_comb begin
      req_ready  = !rst && !flush && (occ_q < DEPTH_C);
      accept     = req_valid && req_ready;
      mul_start  = accept;
      mul_a      = accept ? req_rs1 : '0;
      mul_b      = accept ? req_rs2 : '0;
      mul_ctrl   = accept ? req_funct3 : '0;
      resp_valid = (count_q != '0);
      resp_data  = fifo_data_q[rd_ptr_q];
      resp_rd    = fifo_rd_q[rd_ptr_q];
      busy       = (occ_q != '0);
      // a completion with no live stage-1 entry belongs to a killed op and is dropped
      push       = v1_q && mul_done;
      pop        = resp_valid && resp_ready && !flush;
   end

   // next-state for pipe, pointers, count and occupancy; flush discards everything
   always_comb begin
      v0_d     = accept;
      rd0_d    = req_rd;
      v1_d     = v0_q;
      rd1_d    = rd0_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      occ_d    = occ_q;
      if (push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
         count_d = count_q + cnt_t'(1);
      end else if (pop && !push) begin
         count_d = count_q - cnt_t'(1);
      end
      if (accept && !pop) begin
         occ_d = occ_q + cnt_t'(1);
      end else if (pop && !accept) begin
         occ_d = occ_q - cnt_t'(1);
      end
      if (flush) begin
         v0_d     = 1'b0;
         v1_d     = 1'b0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         occ_d    = '0;
      end
   end

   // control state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         v0_q     <= 1'b0;
         v1_q     <= 1'b0;
         rd0_q    <= '0;
         rd1_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         occ_q    <= '0;
      end else begin
         v0_q     <= v0_d;
         v1_q     <= v1_d;
         rd0_q    <= rd0_d;
         rd1_q    <= rd1_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         occ_q    <= occ_d;
      end
   end

   // buffer storage needs no reset; only entries below count are ever presented
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[wr_ptr_q] <= mul_result;
         fifo_rd_q[wr_ptr_q]   <= rd1_q;
      end
   end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - self-checking bench for mul_issue_ctrl
module tb_mul_issue_ctrl;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_rs1 = '0;
   logic [31:0] req_rs2 = '0;
   logic [4:0]  req_rd = '0;
   logic        flush = 1'b0;
   logic        mul_start;
   logic [31:0] mul_a, mul_b;
   logic [2:0]  mul_ctrl;
   logic [31:0] mul_result;
   logic        mul_done;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit model_on = 1'b0;

   mul_issue_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
      .flush(flush),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_ctrl(mul_ctrl),
      .mul_result(mul_result), .mul_done(mul_done),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_rd(resp_rd), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f);
      logic [63:0] xa, xb, p;
      xa = (f[1:0] == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
      xb = (f[1:0] == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = xa * xb;
      return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // multiplier stand-in: result and done exactly two cycles after start, never stopped by flush
   logic        m1_v = 1'b0, m2_v = 1'b0;
   logic [31:0] m1_r = '0, m2_r = '0;
   always @(posedge clk) begin
      m1_v <= mul_start;
      m1_r <= mul_ref(mul_a, mul_b, mul_ctrl);
      m2_v <= m1_v;
      m2_r <= m1_r;
   end
   assign mul_done   = m2_v;
   assign mul_result = m2_v ? m2_r : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // a live stage-1 entry must always meet a multiplier completion
   always @(negedge clk) begin
      if (model_on && !rst && dut.v1_q === 1'b1) chk("stage1_has_done", {31'b0, mul_done}, 32'd1);
   end

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      int          cyc;
   } ent_t;

   ent_t inflight[$];
   ent_t fifo[$];

   logic        s_req_ready, s_resp_valid, s_busy, s_mul_start;
   logic [31:0] s_resp_data;
   logic [4:0]  s_resp_rd;

   task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f, input logic [4:0] rd);
      req_valid  = v;
      req_rs1    = a;
      req_rs2    = b;
      req_funct3 = f;
      req_rd     = rd;
   endtask

   // one clock: check every output against the queue model, then advance the model
   task automatic tick();
      bit   e_rr, e_rv, acc, pop;
      int   total;
      ent_t e;
      @(negedge clk);
      total = inflight.size() + fifo.size();
      e_rr  = !rst && !flush && (total < DEPTH);
      e_rv  = (fifo.size() > 0);
      acc   = req_valid && e_rr;
      s_req_ready  = req_ready;
      s_resp_valid = resp_valid;
      s_busy       = busy;
      s_mul_start  = mul_start;
      s_resp_data  = resp_data;
      s_resp_rd    = resp_rd;
      if (model_on) begin
         chk("req_ready", {31'b0, req_ready}, {31'b0, e_rr});
         chk("resp_valid", {31'b0, resp_valid}, {31'b0, e_rv});
         chk("busy", {31'b0, busy}, {31'b0, (total > 0)});
         if (e_rv) begin
            chk("resp_data", resp_data, fifo[0].data);
            chk("resp_rd", {27'b0, resp_rd}, {27'b0, fifo[0].rd});
         end
         chk("mul_start", {31'b0, mul_start}, {31'b0, acc});
         chk("mul_a", mul_a, acc ? req_rs1 : 32'd0);
         chk("mul_b", mul_b, acc ? req_rs2 : 32'd0);
         chk("mul_ctrl", {29'b0, mul_ctrl}, acc ? {29'b0, req_funct3} : 32'd0);
      end
      pop = e_rv && resp_ready && !flush;
      @(posedge clk);
      if (rst || flush) begin
         inflight.delete();
         fifo.delete();
      end else begin
         if (pop) void'(fifo.pop_front());
         if (inflight.size() > 0 && inflight[0].cyc + 2 == cyc) begin
            e = inflight.pop_front();
            fifo.push_back(e);
         end
         if (acc) begin
            e.data = mul_ref(req_rs1, req_rs2, req_funct3);
            e.rd   = req_rd;
            e.cyc  = cyc;
            inflight.push_back(e);
         end
      end
      model_on = 1'b1;
      cyc++;
      #1;
   endtask

   task automatic single_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] f, input logic [4:0] rd, input logic [31:0] exp);
      drive(1, a, b, f, rd);
      tick();
      chk({tag, "_start_T"}, {31'b0, s_mul_start}, 32'd1);
      drive(0, 0, 0, 0, 0);
      tick();
      chk({tag, "_start_T1"}, {31'b0, s_mul_start}, 32'd0);
      tick();
      chk({tag, "_valid_T2"}, {31'b0, s_resp_valid}, 32'd0);
      tick();
      chk({tag, "_valid_T3"}, {31'b0, s_resp_valid}, 32'd1);
      chk({tag, "_data"}, s_resp_data, exp);
      chk({tag, "_rd"}, {27'b0, s_resp_rd}, {27'b0, rd});
      tick();
      chk({tag, "_busy_T4"}, {31'b0, s_busy}, 32'd0);
   endtask

   initial begin
      int acc_cnt;

      // reset
      tick();
      tick();
      chk("reset_resp_valid", {31'b0, s_resp_valid}, 32'd0);
      chk("reset_busy", {31'b0, s_busy}, 32'd0);
      chk("reset_req_ready", {31'b0, s_req_ready}, 32'd0);
      rst = 1'b0;
      tick();
      chk("post_reset_ready", {31'b0, s_req_ready}, 32'd1);

      // single ops and high-half variants
      resp_ready = 1'b1;
      single_op("mul7x6", 32'd7, 32'd6, 3'b000, 5'd5, 32'd42);
      single_op("mulh_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 5'd6, 32'h0000_0000);
      single_op("mulhu_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 5'd7, 32'hFFFF_FFFE);
      single_op("mulhsu_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 5'd8, 32'hFFFF_FFFF);
      single_op("mulh_min", 32'h8000_0000, 32'd2, 3'b001, 5'd9, 32'hFFFF_FFFF);

      // back-to-back stream of 8
      for (int k = 0; k < 11; k++) begin
         if (k < 8) drive(1, 32'(k + 1), 32'(k + 2), 3'b000, 5'(k + 1));
         else drive(0, 0, 0, 0, 0);
         tick();
         if (k < 8) chk("stream_ready", {31'b0, s_req_ready}, 32'd1);
         if (k >= 3) begin
            chk("stream_valid", {31'b0, s_resp_valid}, 32'd1);
            chk("stream_rd", {27'b0, s_resp_rd}, 32'(k - 2));
            chk("stream_data", s_resp_data, 32'((k - 2) * (k - 1)));
         end
      end
      tick();

      // backpressure
      resp_ready = 1'b0;
      acc_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1, 32'(i + 1), 32'd3, 3'b000, 5'(10 + i));
         tick();
         if (s_req_ready) acc_cnt++;
      end
      chk("bp_accepts", 32'(acc_cnt), 32'd4);
      chk("bp_ready_low", {31'b0, s_req_ready}, 32'd0);
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("bp_head_rd", {27'b0, s_resp_rd}, 32'd10);
         chk("bp_head_data", s_resp_data, 32'd3);
      end
      resp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("drain_valid", {31'b0, s_resp_valid}, 32'd1);
         chk("drain_rd", {27'b0, s_resp_rd}, 32'(10 + k));
         if (k == 0) chk("drain_ready_at_pop", {31'b0, s_req_ready}, 32'd0);
         if (k == 1) chk("drain_ready_after_pop", {31'b0, s_req_ready}, 32'd1);
      end
      tick();
      chk("drain_empty", {31'b0, s_resp_valid}, 32'd0);

      // flush with two ops in flight
      drive(1, 32'd11, 32'd12, 3'b000, 5'd3);
      tick();
      drive(1, 32'd13, 32'd14, 3'b000, 5'd4);
      tick();
      drive(0, 0, 0, 0, 0);
      flush = 1'b1;
      tick();
      chk("flush_no_valid_T2", {31'b0, s_resp_valid}, 32'd0);
      chk("flush_ready_low", {31'b0, s_req_ready}, 32'd0);
      flush = 1'b0;
      drive(1, 32'd3, 32'd5, 3'b000, 5'd9);
      tick();
      chk("flush_busy_T3", {31'b0, s_busy}, 32'd0);
      chk("flush_no_valid_T3", {31'b0, s_resp_valid}, 32'd0);
      chk("flush_reaccept", {31'b0, s_mul_start}, 32'd1);
      drive(0, 0, 0, 0, 0);
      tick();
      chk("flush_no_valid_T4", {31'b0, s_resp_valid}, 32'd0);
      tick();
      chk("flush_no_valid_T5", {31'b0, s_resp_valid}, 32'd0);
      tick();
      chk("flush_new_valid_T6", {31'b0, s_resp_valid}, 32'd1);
      chk("flush_new_data", s_resp_data, 32'd15);
      chk("flush_new_rd", {27'b0, s_resp_rd}, 32'd9);
      tick();

      // reset with three buffered entries
      resp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'(i + 2), 32'd2, 3'b000, 5'(20 + i));
         tick();
      end
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick();
      chk("rst_pre_valid", {31'b0, s_resp_valid}, 32'd1);
      rst = 1'b1;
      tick();
      tick();
      chk("rst_mid_valid", {31'b0, s_resp_valid}, 32'd0);
      chk("rst_mid_busy", {31'b0, s_busy}, 32'd0);
      chk("rst_mid_ready", {31'b0, s_req_ready}, 32'd0);
      rst = 1'b0;
      tick();
      chk("rst_after_ready", {31'b0, s_req_ready}, 32'd1);
      chk("rst_after_valid", {31'b0, s_resp_valid}, 32'd0);

      // randomized traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), $urandom, $urandom, 3'($urandom_range(0, 7)),
               5'($urandom_range(0, 31)));
         resp_ready = ($urandom_range(0, 2) != 0);
         flush      = ($urandom_range(0, 24) == 0);
         rst        = ($urandom_range(0, 99) == 0);
         tick();
      end
      drive(0, 0, 0, 0, 0);
      flush = 1'b0;
      rst = 1'b0;
      resp_ready = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("final_idle", {31'b0, s_busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
